// File: rtl/egg_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : egg_timer_pkg
//  Description : Shared channel state encoding, default 5 MHz timing constants
//                and counter-width helpers for the egg timer button path.
//  Revision    : 1.0  initial release
// ============================================================================
package egg_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HOLD         = 2'd1,
        ST_REPEAT       = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } chan_state_t;

    localparam int unsigned c_DEBOUNCE_CYC  = 50000;    // 10 ms
    localparam int unsigned c_REPEAT_DELAY  = 2500000;  // 500 ms
    localparam int unsigned c_REPEAT_PERIOD = 500000;   // 100 ms

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One button path: 2-FF synchronizer, counting debouncer and a
//                press/auto-repeat FSM producing registered one-cycle pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_channel
    import egg_timer_pkg::*;
#(
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned DEBOUNCE_CYC  = c_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY  = c_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = c_REPEAT_PERIOD
) (
    input  logic clk_5,
    input  logic reset,
    input  logic raw,
    input  logic gate,
    output logic level,
    output logic pulse
);

    localparam int unsigned c_DB_W = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned c_RP_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [c_DB_W-1:0] c_DB_LAST    = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_RP_W-1:0] c_DELAY_LAST = c_RP_W'(REPEAT_DELAY - 1);
    localparam logic [c_RP_W-1:0] c_PER_LAST   = c_RP_W'(REPEAT_PERIOD - 1);
    localparam logic [c_RP_W-1:0] c_RP_MAX     = {c_RP_W{1'b1}};

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic              r_level_d;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [c_RP_W-1:0] r_rpt_cnt;
    logic              r_pulse;
    chan_state_t       r_state;

    chan_state_t       w_state_nxt;
    logic [c_RP_W-1:0] w_rpt_cnt_nxt;
    logic [c_RP_W-1:0] w_rpt_inc;
    logic              w_pulse_nxt;
    logic              w_rise;

    // Synchronizer and debouncer: the level only moves after DEBOUNCE_CYC
    // consecutive cycles of disagreement with the synchronized input.
    always_ff @(posedge clk_5 or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt >= c_DB_LAST) begin
                r_level  <= ~r_level;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_5 or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_pulse   <= w_pulse_nxt;
        end
    end

    assign w_rise    = r_level & ~r_level_d;
    assign w_rpt_inc = (r_rpt_cnt == c_RP_MAX) ? r_rpt_cnt : r_rpt_cnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_pulse_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    if (gate) begin
                        w_state_nxt   = ST_HOLD;
                        w_pulse_nxt   = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_WAIT_RELEASE;
                    end
                end
            end
            ST_HOLD: begin
                if (!r_level) begin
                    w_state_nxt = ST_IDLE;
                end else if (!gate) begin
                    w_state_nxt = ST_WAIT_RELEASE;
                end else if (REPEAT_EN) begin
                    if (r_rpt_cnt == c_DELAY_LAST) begin
                        w_state_nxt   = ST_REPEAT;
                        w_pulse_nxt   = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = w_rpt_inc;
                    end
                end
            end
            ST_REPEAT: begin
                if (!r_level) begin
                    w_state_nxt = ST_IDLE;
                end else if (!gate) begin
                    w_state_nxt = ST_WAIT_RELEASE;
                end else if (r_rpt_cnt == c_PER_LAST) begin
                    w_pulse_nxt   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                end else begin
                    w_rpt_cnt_nxt = w_rpt_inc;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!r_level) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Converts raw modify/min/sec/start buttons into a debounced
//                modify level and gated one-cycle command pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module button_conditioner
    import egg_timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = c_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY  = c_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = c_REPEAT_PERIOD
) (
    input  logic clk_5,
    input  logic reset,
    input  logic btn_modify,
    input  logic btn_min,
    input  logic btn_sec,
    input  logic btn_start,
    output logic modify_active,
    output logic inc_min_pulse,
    output logic inc_sec_pulse,
    output logic start_pulse
);

    logic w_modify_level;
    logic w_modify_pulse_unused;
    logic w_min_level_unused;
    logic w_sec_level_unused;
    logic w_start_level_unused;

    btn_channel #(
        .REPEAT_EN    (1'b0),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_modify (
        .clk_5(clk_5),
        .reset(reset),
        .raw  (btn_modify),
        .gate (1'b1),
        .level(w_modify_level),
        .pulse(w_modify_pulse_unused)
    );

    btn_channel #(
        .REPEAT_EN    (1'b1),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_min (
        .clk_5(clk_5),
        .reset(reset),
        .raw  (btn_min),
        .gate (w_modify_level),
        .level(w_min_level_unused),
        .pulse(inc_min_pulse)
    );

    btn_channel #(
        .REPEAT_EN    (1'b1),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_sec (
        .clk_5(clk_5),
        .reset(reset),
        .raw  (btn_sec),
        .gate (w_modify_level),
        .level(w_sec_level_unused),
        .pulse(inc_sec_pulse)
    );

    // Start is gated by the inverse of modify, so it can never coincide with min/sec.
    btn_channel #(
        .REPEAT_EN    (1'b0),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_start (
        .clk_5(clk_5),
        .reset(reset),
        .raw  (btn_start),
        .gate (~w_modify_level),
        .level(w_start_level_unused),
        .pulse(start_pulse)
    );

    assign modify_active = w_modify_level;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed bench for button_conditioner with short debounce and
//                repeat timing; pulse times are logged and compared to offsets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_conditioner;

    logic clk_5      = 1'b0;
    logic reset      = 1'b1;
    logic btn_modify = 1'b0;
    logic btn_min    = 1'b0;
    logic btn_sec    = 1'b0;
    logic btn_start  = 1'b0;
    logic modify_active;
    logic inc_min_pulse;
    logic inc_sec_pulse;
    logic start_pulse;

    button_conditioner #(
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk_5        (clk_5),
        .reset        (reset),
        .btn_modify   (btn_modify),
        .btn_min      (btn_min),
        .btn_sec      (btn_sec),
        .btn_start    (btn_start),
        .modify_active(modify_active),
        .inc_min_pulse(inc_min_pulse),
        .inc_sec_pulse(inc_sec_pulse),
        .start_pulse  (start_pulse)
    );

    always #5 clk_5 = ~clk_5;

    int cyc = 0;
    always @(posedge clk_5) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int q_min[$];
    int q_sec[$];
    int q_start[$];
    int viol = 0;
    logic prev_min = 1'b0, prev_sec = 1'b0, prev_start = 1'b0;

    // Pulse log plus overlap / back-to-back watchdog.
    always @(negedge clk_5) begin
        if (inc_min_pulse) q_min.push_back(cyc);
        if (inc_sec_pulse) q_sec.push_back(cyc);
        if (start_pulse)   q_start.push_back(cyc);
        if ((inc_min_pulse || inc_sec_pulse) && start_pulse) viol++;
        if ((inc_min_pulse && prev_min) || (inc_sec_pulse && prev_sec) ||
            (start_pulse && prev_start)) viol++;
        prev_min   = inc_min_pulse;
        prev_sec   = inc_sec_pulse;
        prev_start = start_pulse;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_5);
        #1;
    endtask

    task automatic clear_log();
        q_min.delete();
        q_sec.delete();
        q_start.delete();
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    int t0;
    int rep_ofs[6] = '{7, 27, 35, 43, 51, 59};

    initial begin
        // All buttons held through reset
        btn_modify = 1'b1; btn_min = 1'b1; btn_sec = 1'b1; btn_start = 1'b1;
        idle(3);
        check_val("rst_modify", int'(modify_active), 0);
        check_val("rst_pulses", int'({inc_min_pulse, inc_sec_pulse, start_pulse}), 0);
        reset = 1'b0;
        t0 = cyc;
        idle(5);
        check_val("mod_before6", int'(modify_active), 0);
        idle(1);
        check_val("mod_at6", int'(modify_active), 1);
        check_val("sec_at6", int'(inc_sec_pulse), 0);
        idle(1);
        check_val("sec_at7", int'(inc_sec_pulse), 1);
        check_val("min_at7", int'(inc_min_pulse), 1);
        check_val("start_at7", int'(start_pulse), 0);
        idle(33);
        check_val("t1_sec_cnt", q_sec.size(), 3);
        check_val("t1_min_cnt", q_min.size(), 3);
        check_val("t1_start_cnt", q_start.size(), 0);
        check_val("t1_sec_first", q_at(q_sec, 0) - t0, 7);
        check_val("t1_min_rep", q_at(q_min, 1) - t0, 27);
        btn_modify = 1'b0; btn_min = 1'b0; btn_sec = 1'b0; btn_start = 1'b0;
        idle(20);

        // Bouncy sec press
        btn_modify = 1'b1;
        idle(10);
        clear_log();
        for (int k = 0; k < 4; k++) begin
            btn_sec = (k % 2 == 0);
            idle(3);
        end
        btn_sec = 1'b1;
        t0 = cyc;
        idle(10);
        btn_sec = 1'b0;
        idle(15);
        check_val("t2_sec_cnt", q_sec.size(), 1);
        check_val("t2_sec_lat", q_at(q_sec, 0) - t0, 7);
        check_val("t2_other", q_min.size() + q_start.size(), 0);

        // Min held into auto-repeat
        clear_log();
        btn_min = 1'b1;
        t0 = cyc;
        idle(60);
        btn_min = 1'b0;
        idle(15);
        check_val("t3_min_cnt", q_min.size(), 6);
        for (int i = 0; i < 6; i++)
            check_val($sformatf("t3_min_ofs%0d", i), q_at(q_min, i) - t0, rep_ofs[i]);

        // Start gating
        btn_modify = 1'b0;
        idle(10);
        clear_log();
        btn_start = 1'b1;
        t0 = cyc;
        idle(50);
        btn_start = 1'b0;
        idle(15);
        check_val("t4_start_cnt", q_start.size(), 1);
        check_val("t4_start_lat", q_at(q_start, 0) - t0, 7);
        check_val("t4_minsec", q_min.size() + q_sec.size(), 0);
        btn_modify = 1'b1;
        idle(10);
        clear_log();
        btn_start = 1'b1;
        idle(50);
        btn_start = 1'b0;
        idle(15);
        check_val("t4_start_gated", q_start.size(), 0);

        // Modify dropped during repeat, re-raised while still held
        clear_log();
        btn_sec = 1'b1;
        t0 = cyc;
        idle(30);
        btn_modify = 1'b0;
        idle(20);
        check_val("t5_mod_low", int'(modify_active), 0);
        check_val("t5_sec_cnt", q_sec.size(), 3);
        check_val("t5_sec_last", q_at(q_sec, 2) - t0, 35);
        btn_modify = 1'b1;
        idle(40);
        check_val("t5_no_regate", q_sec.size(), 3);
        btn_sec = 1'b0;
        idle(15);
        btn_sec = 1'b1;
        t0 = cyc;
        idle(12);
        check_val("t5_repress_cnt", q_sec.size(), 4);
        check_val("t5_repress_lat", q_at(q_sec, 3) - t0, 7);
        btn_sec = 1'b0;
        idle(15);

        // Reset during repeat
        clear_log();
        btn_min = 1'b1;
        idle(30);
        check_val("t6_pre_cnt", q_min.size(), 2);
        reset = 1'b1;
        idle(1);
        check_val("t6_rst_out",
                  int'({modify_active, inc_min_pulse, inc_sec_pulse, start_pulse}), 0);
        idle(2);
        clear_log();
        reset = 1'b0;
        t0 = cyc;
        idle(20);
        check_val("t6_post_cnt", q_min.size(), 1);
        check_val("t6_post_lat", q_at(q_min, 0) - t0, 7);
        check_val("t6_post_other", q_sec.size() + q_start.size(), 0);
        btn_min = 1'b0;
        idle(15);

        check_val("no_overlap", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
